alu_muldiv: RTL and testbench

Iterative multiply/divide unit for the ja88 execution stage, the sequential companion to the single-cycle ALU. It performs MUL, IMUL, DIV and IDIV on 8/16/32-bit operands, parametrised by maximum datapath width. It uses one shift/add or shift/subtract step per clock and a start/busy/done handshake. Divide errors (#DE) are reported on a dedicated output, and the microcode sequencer raises the interrupt.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state encoding and width helper for alu_muldiv
package alu_pkg;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_IMUL = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_IDIV = 2'd3;

    localparam int FL_C = 0;
    localparam int FL_P = 2;
    localparam int FL_A = 4;
    localparam int FL_Z = 6;
    localparam int FL_S = 7;
    localparam int FL_O = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [5:0] n_of(input logic isize, input logic opsize);
        if (!isize) begin
            return 6'd8;
        end
        return opsize ? 6'd32 : 6'd16;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative MUL/IMUL/DIV/IDIV unit, one shift/add or shift/subtract step per clock
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             isize,
    input  logic             opsize,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op1hi,
    input  logic [WIDTH-1:0] op2,
    input  logic [11:0]      flags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [11:0]      flags_o,
    output logic             exc
);

    localparam int W2 = 2 * WIDTH;

    state_t           state, state_nx;
    logic [1:0]       mode_q;
    logic [5:0]       n_q, count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             neg_res, neg_rem;
    logic [11:0]      flags_q;

    logic [5:0]       n_in, n_cur;
    logic [WIDTH-1:0] mask_cur, top_cur;
    logic             is_div_in, is_sgn_in, sign_a, sign_b, early_exc;
    logic [WIDTH-1:0] a_lo, a_hi, b_in, mag_lo, mag_hi, mag_b;
    logic [W2-1:0]    wide_src, wide_neg;
    logic [WIDTH-1:0] neg_lo, neg_hi, narrow_src, narrow_neg;
    logic [WIDTH:0]   mul_sum, div_rem;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem;
    logic             mul_ovf, quot_ovf;
    logic [11:0]      mul_flags;

    function automatic logic [WIDTH-1:0] mask_of(input logic [5:0] n);
        return {WIDTH{1'b1}} >> (6'(WIDTH) - n);
    endfunction

    function automatic logic [W2-1:0] join_n(input logic [WIDTH-1:0] hi,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [5:0] n);
        return (W2'(hi) << n) | W2'(lo);
    endfunction

    assign n_in = n_of(isize, opsize && (WIDTH == 32));

    // One wide and one narrow negator serve both operand abs at capture and sign fix-up in FIX.
    always_comb begin
        n_cur      = (state == ST_IDLE) ? n_in : n_q;
        mask_cur   = mask_of(n_cur);
        top_cur    = mask_cur ^ (mask_cur >> 1);
        is_div_in  = (mode == MD_DIV) || (mode == MD_IDIV);
        is_sgn_in  = (mode == MD_IMUL) || (mode == MD_IDIV);
        a_lo       = op1 & mask_cur;
        a_hi       = is_div_in ? (op1hi & mask_cur) : '0;
        b_in       = op2 & mask_cur;
        sign_a     = is_sgn_in && (((is_div_in ? a_hi : a_lo) & top_cur) != '0);
        sign_b     = is_sgn_in && ((b_in & top_cur) != '0);
        if (state == ST_IDLE) begin
            wide_src   = join_n(a_hi, a_lo, n_cur);
            narrow_src = b_in;
        end else begin
            wide_src   = join_n(mode_q[1] ? '0 : acc_hi, acc_lo, n_cur);
            narrow_src = acc_hi;
        end
        wide_neg   = (~wide_src + 1'b1) & join_n(mask_cur, mask_cur, n_cur);
        narrow_neg = (~narrow_src + 1'b1) & mask_cur;
        neg_lo     = WIDTH'(wide_neg) & mask_cur;
        neg_hi     = WIDTH'(wide_neg >> n_cur) & mask_cur;
        mag_lo     = sign_a ? neg_lo : a_lo;
        mag_hi     = sign_a ? neg_hi : a_hi;
        mag_b      = sign_b ? narrow_neg : b_in;
        early_exc  = is_div_in && ((mag_b == '0) || (mag_hi >= mag_b));
    end

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_rem  = {acc_hi, (acc_lo & top_cur) != '0};
        div_ge   = div_rem >= {1'b0, opnd};
        div_sub  = div_rem[WIDTH-1:0] - opnd;
        prod_lo  = neg_res ? neg_lo : acc_lo;
        prod_hi  = neg_res ? neg_hi : acc_hi;
        mul_ovf  = (mode_q == MD_IMUL)
                 ? (prod_hi != (((prod_lo & top_cur) != '0) ? mask_cur : '0))
                 : (prod_hi != '0);
        quot     = neg_res ? neg_lo : acc_lo;
        rem      = neg_rem ? narrow_neg : acc_hi;
        // Negative quotients may reach -2^(n-1); positive ones stop at 2^(n-1)-1.
        quot_ovf = (mode_q == MD_IDIV) && (neg_res ? (acc_lo > top_cur) : (acc_lo >= top_cur));
        mul_flags       = flags_q;
        mul_flags[FL_O] = mul_ovf;
        mul_flags[FL_C] = mul_ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        case (state)
            ST_IDLE: if (start) state_nx = early_exc ? ST_DONE : ST_CALC;
            ST_CALC: if (count == 6'd1) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q    <= MD_MUL;
            n_q       <= 6'd8;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            flags_q   <= 12'h002;
            result_lo <= '0;
            result_hi <= '0;
            flags_o   <= 12'h002;
            exc       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mode_q  <= mode;
                    n_q     <= n_in;
                    count   <= n_in;
                    neg_res <= sign_a ^ sign_b;
                    neg_rem <= sign_a;
                    flags_q <= flags;
                    exc     <= early_exc;
                    if (is_div_in) begin
                        acc_hi <= mag_hi;
                        acc_lo <= mag_lo;
                        opnd   <= mag_b;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        opnd   <= mag_lo;
                    end
                    if (early_exc) flags_o <= flags;
                end
                ST_CALC: begin
                    count <= count - 6'd1;
                    if (mode_q[1]) begin
                        acc_hi <= div_ge ? div_sub : div_rem[WIDTH-1:0];
                        acc_lo <= ((acc_lo << 1) | WIDTH'(div_ge)) & mask_cur;
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= (acc_lo >> 1) | (mul_sum[0] ? top_cur : '0);
                    end
                end
                ST_FIX: begin
                    if (!mode_q[1]) begin
                        result_lo <= prod_lo;
                        result_hi <= prod_hi;
                        flags_o   <= mul_flags;
                    end else if (quot_ovf) begin
                        exc     <= 1'b1;
                        flags_o <= flags_q;
                    end else begin
                        result_lo <= quot;
                        result_hi <= rem;
                        flags_o   <= flags_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed vector bench for alu_muldiv
module tb_alu_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        isize = 1'b0;
    logic        opsize = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op1hi = '0;
    logic [31:0] op2 = '0;
    logic [11:0] flags = 12'h002;
    logic        busy, done, exc;
    logic [31:0] result_lo, result_hi;
    logic [11:0] flags_o;

    always #5 clock = ~clock;

    alu_muldiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .isize(isize), .opsize(opsize), .op1(op1), .op1hi(op1hi), .op2(op2),
        .flags(flags), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .flags_o(flags_o), .exc(exc)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        isize;
        logic        opsize;
        logic [31:0] op1hi;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [11:0] flags;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic [11:0] exp_flags;
        logic        exp_exc;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c;
        mode   = v.mode;
        isize  = v.isize;
        opsize = v.opsize;
        op1hi  = v.op1hi;
        op1    = v.op1;
        op2    = v.op2;
        flags  = v.flags;
        start  = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                op1   = $urandom;
                op1hi = $urandom;
                op2   = $urandom;
                flags = 12'($urandom);
            end
        end while (!done && c < 60);
        check($sformatf("v%0d latency", idx), 64'(c), 64'(v.lat));
        check($sformatf("v%0d result_lo", idx), 64'(result_lo), 64'(v.exp_lo));
        check($sformatf("v%0d result_hi", idx), 64'(result_hi), 64'(v.exp_hi));
        check($sformatf("v%0d flags_o", idx), 64'(flags_o), 64'(v.exp_flags));
        check($sformatf("v%0d exc", idx), 64'(exc), 64'(v.exp_exc));
        check($sformatf("v%0d busy_at_done", idx), 64'(busy), 64'd1);
        @(negedge clock);
        check($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d done_after", idx), 64'(done), 64'd0);
    endtask

    initial begin
        int c, dones, first;
        //          mode  isz   osz   op1hi          op1            op2            flags    exp_lo         exp_hi         exp_fl   exc  lat
        vecs[0]  = '{2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_00FF, 32'h0000_00FF, 12'h0C2, 32'h0000_0001, 32'h0000_00FE, 12'h8C3, 1'b0, 10};
        vecs[1]  = '{2'd1, 1'b1, 1'b0, 32'h0,         32'h0000_FFFE, 32'h0000_0003, 12'h8C3, 32'h0000_FFFA, 32'h0000_FFFF, 12'h0C2, 1'b0, 18};
        vecs[2]  = '{2'd2, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 12'h246, 32'h8000_0000, 32'h0000_0000, 12'h246, 1'b0, 34};
        vecs[3]  = '{2'd2, 1'b1, 1'b0, 32'h0,         32'h0000_1234, 32'h0000_0000, 12'h002, 32'h8000_0000, 32'h0000_0000, 12'h002, 1'b1, 1};
        vecs[4]  = '{2'd3, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_00F9, 32'h0000_0002, 12'h046, 32'h0000_00FD, 32'h0000_00FF, 12'h046, 1'b0, 10};
        vecs[5]  = '{2'd3, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0080, 32'h0000_0001, 12'h893, 32'h0000_00FD, 32'h0000_00FF, 12'h893, 1'b1, 10};
        vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'h0,         32'hABCD_1234, 32'hFFFF_0010, 12'h002, 32'h0000_2340, 32'h0000_0001, 12'h803, 1'b0, 18};
        vecs[7]  = '{2'd1, 1'b0, 1'b0, 32'h0,         32'h0000_0080, 32'h0000_0080, 12'h002, 32'h0000_0000, 32'h0000_0040, 12'h803, 1'b0, 10};
        vecs[8]  = '{2'd1, 1'b1, 1'b1, 32'h0,         32'hFFFF_FFFF, 32'h0000_0005, 12'h803, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 12'h002, 1'b0, 34};
        vecs[9]  = '{2'd2, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 12'h0D7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 12'h0D7, 1'b1, 1};
        vecs[10] = '{2'd3, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0064, 32'h0000_FFF9, 12'h012, 32'h0000_FFF2, 32'h0000_0002, 12'h012, 1'b0, 18};
        vecs[11] = '{2'd3, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0080, 32'h0000_0001, 12'h002, 32'h0000_0080, 32'h0000_0000, 12'h002, 1'b0, 10};
        vecs[12] = '{2'd2, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'h8D5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 12'h8D5, 1'b0, 34};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset exc", 64'(exc), 64'd0);
        check("reset result_lo", 64'(result_lo), 64'd0);
        check("reset result_hi", 64'(result_hi), 64'd0);
        check("reset flags_o", 64'(flags_o), 64'h002);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a 32-bit divide aborts with no done pulse.
        mode = 2'd2; isize = 1'b1; opsize = 1'b1;
        op1hi = 32'h1; op1 = 32'h0; op2 = 32'h2; flags = 12'h246;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("abort done_pulses", 64'(dones), 64'd0);
        check("abort busy_later", 64'(busy), 64'd0);
        check("abort result_lo", 64'(result_lo), 64'd0);
        check("abort result_hi", 64'(result_hi), 64'd0);
        check("abort flags_o", 64'(flags_o), 64'h002);
        check("abort exc", 64'(exc), 64'd0);

        // start held high through a whole MUL: one operation, operands frozen at capture.
        mode = 2'd0; isize = 1'b0; opsize = 1'b0;
        op1hi = 32'h0; op1 = 32'hFF; op2 = 32'hFF; flags = 12'h0C2;
        start = 1'b1;
        c = 0; dones = 0; first = 0;
        repeat (30) begin
            @(negedge clock);
            c++;
            if (c == 3) begin
                op1 = 32'h0;
                op2 = 32'h3;
            end
            if (done) begin
                dones++;
                if (first == 0) first = c;
                start = 1'b0;
            end
        end
        check("held done_pulses", 64'(dones), 64'd1);
        check("held latency", 64'(first), 64'd10);
        check("held result_lo", 64'(result_lo), 64'h01);
        check("held result_hi", 64'(result_hi), 64'hFE);
        check("held flags_o", 64'(flags_o), 64'h8C3);
        check("held busy_end", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
